// File: rtl/wb_dma_master_pkg.sv
// Shared types and constants for the Wishbone block-copy DMA master.
// Holds the FSM state encoding, the byte-select and zero-word constants, and a word-align helper.
package wb_dma_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_RGAP = 3'd2,
        ST_WR   = 3'd3,
        ST_WGAP = 3'd4,
        ST_DONE = 3'd5
    } dma_state_e;

    localparam logic [3:0]  WB_SEL_ALL = 4'b1111;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [31:0] WORD_STEP  = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_dma_master_if.sv
// Wishbone classic bus bundle between the DMA master and the interconnect master port.
// Signal directions are named from the master's point of view.
interface wb_dma_master_if;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;

    modport master (
        output adr, dat_o, sel, we, cyc, stb,
        input  dat_i, ack, err
    );

    modport slave (
        input  adr, dat_o, sel, we, cyc, stb,
        output dat_i, ack, err
    );
endinterface

// File: rtl/wb_dma_master_wdog.sv
// Bus watchdog: down-counter reloaded whenever no access is pending, expiring on the
// TIMEOUT-th consecutive strobe cycle without a response. TIMEOUT=0 disables it.
module wb_dma_wdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count is reached while the last permitted strobe cycle is still on the bus.
    assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == '0);

endmodule

// File: rtl/wb_dma_master.sv
// Wishbone classic-cycle DMA master: copies len 32-bit words from src to dst,
// one read then one write per word, with an idle gap after each access for rearbitration.
//
// state | meaning
// IDLE  | waiting for start_i
// RD    | read access to src pending (cyc/stb high, we low)
// RGAP  | bus released after read, word held in buffer
// WR    | write access to dst pending (cyc/stb/we high)
// WGAP  | bus released after write, decide next word or finish
// DONE  | one-cycle done_o pulse, then back to IDLE
module wb_dma_master
    import wb_dma_master_pkg::*;
#(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    wb_dma_master_if.master  wb
);

    dma_state_e       state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      buf_q, buf_d;

    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [3:0]       sel_q, sel_d;
    logic             we_q, we_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             bus_ok;
    logic             bus_abort;
    logic             wdog_expired;

    // Responses only count while our strobe is out; err takes priority over ack.
    assign bus_ok    = stb_q && wb.ack && !wb.err;
    assign bus_abort = (stb_q && wb.err) || wdog_expired;

    wb_dma_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (!stb_q || bus_ok),
        .en_i      (stb_q),
        .expired_o (wdog_expired)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    src_d   = word_align(src_addr_i);
                    dst_d   = word_align(dst_addr_i);
                    cnt_d   = len_i;
                    err_d   = 1'b0;
                    state_d = (len_i == '0) ? ST_DONE : ST_RD;
                end
            end
            ST_RD: begin
                if (bus_abort) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (bus_ok) begin
                    buf_d   = wb.dat_i;
                    src_d   = src_q + WORD_STEP;
                    state_d = ST_RGAP;
                end
            end
            ST_RGAP: begin
                state_d = ST_WR;
            end
            ST_WR: begin
                if (bus_abort) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (bus_ok) begin
                    dst_d   = dst_q + WORD_STEP;
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = ST_WGAP;
                end
            end
            ST_WGAP: begin
                state_d = (cnt_q == '0) ? ST_DONE : ST_RD;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus outputs are decoded from the next state so they leave a flop
        // in the same cycle the FSM enters RD/WR; adr/dat stay frozen while waiting.
        cyc_d  = (state_d == ST_RD) || (state_d == ST_WR);
        stb_d  = cyc_d;
        we_d   = (state_d == ST_WR);
        sel_d  = cyc_d ? WB_SEL_ALL : 4'b0000;
        adr_d  = (state_d == ST_RD) ? src_d :
                 (state_d == ST_WR) ? dst_d : ZERO_WORD;
        dat_d  = (state_d == ST_WR) ? buf_d : ZERO_WORD;
        busy_d = (state_d == ST_RD) || (state_d == ST_RGAP) ||
                 (state_d == ST_WR) || (state_d == ST_WGAP);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            src_q   <= ZERO_WORD;
            dst_q   <= ZERO_WORD;
            cnt_q   <= '0;
            buf_q   <= ZERO_WORD;
            adr_q   <= ZERO_WORD;
            dat_q   <= ZERO_WORD;
            sel_q   <= 4'b0000;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wb.adr   = adr_q;
    assign wb.dat_o = dat_q;
    assign wb.sel   = sel_q;
    assign wb.we    = we_q;
    assign wb.cyc   = cyc_q;
    assign wb.stb   = stb_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;

endmodule
